serial_sum_collector: RTL and testbench
=======================================

SERIAL_SUM_COLLECTOR -- requirements
Module: serial_sum_collector

Interface
REQ-001 Parameter: W, default 4, number of serial sum bits per word (W >= 2).
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: sum_in  in  1  serial sum bit from the serial adder, LSB first.
REQ-005 Port: cy_in  in  1  carry from the serial adder; sampled only on the MSB cycle.
REQ-006 Port: start  in  1  high on the cycle that sum_in carries bit 0 of a new word.
REQ-007 Port: res_ready  in  1  consumer accepts res_data when high with res_valid.
REQ-008 Port: res_data  out  W+1  assembled result {carry, sum[W-1:0]}.
REQ-009 Port: res_valid  out  1  res_data holds an unconsumed word.
REQ-010 Port: busy  out  1  high while the collector is in COLLECT.
REQ-011 Port: ovf_err  out  1  sticky; a completed word was dropped.
REQ-012 Port: sync_err  out  1  sticky; start arrived mid-word.

Function
REQ-013 The FSM SHALL have two states: IDLE and COLLECT.
REQ-014 In IDLE with start=1, the block SHALL write sum_in into shift bit 0, set bit count to 1, and go to COLLECT.
REQ-015 In IDLE with start=0, the block SHALL ignore sum_in and cy_in.
REQ-016 In COLLECT with start=0, each cycle SHALL write sum_in into bit[count] and increment count.
REQ-017 On the cycle with count = W-1, the block SHALL capture sum_in as bit W-1 and cy_in as bit W (the MSB cycle).
REQ-018 On the MSB cycle the word SHALL be complete and the FSM SHALL return to IDLE.
REQ-019 A start on the cycle immediately after the MSB cycle SHALL begin a new word with no gap cycle.
REQ-020 In COLLECT with start=1, the block SHALL discard the partial word, restart with sum_in as bit 0 and count = 1, and set sync_err.
REQ-021 Output buffering: a separate output register SHALL hold res_data, so collection proceeds while a result is held.
REQ-022 On a completed word, the output register SHALL load when it is empty or is being drained that cycle (res_valid & res_ready).
REQ-023 res_valid SHALL rise on the clock edge ending the MSB cycle.
REQ-024 Latency: with start in cycle 0, res_valid SHALL be visible in cycle W.
REQ-025 On a completed word with res_valid=1 and res_ready=0, the new word SHALL be dropped, res_data SHALL be kept, and ovf_err SHALL be set.
REQ-026 res_valid & res_ready SHALL clear res_valid at the next edge unless a word completes in the same cycle, in which case res_valid stays 1 with the new data.
REQ-027 While res_valid=1 and res_ready=0, res_data SHALL remain stable.
REQ-028 busy SHALL be 1 exactly when state = COLLECT.
REQ-029 ovf_err and sync_err SHALL clear only on rst.
REQ-030 Arithmetic rule: res_data = {cy_in@MSB, sum bits}; no arithmetic is performed inside the block.

Reset
REQ-031 With rst=1 at a rising edge, the block SHALL set state=IDLE, count=0, shift register=0, res_data=0, res_valid=0, busy=0, ovf_err=0, sync_err=0.
REQ-032 rst SHALL take priority over start, res_ready, and word completion in the same cycle.
REQ-033 rst asserted mid-word SHALL abandon the partial word; no result is produced and no error is flagged.

Verification (W=4)
REQ-034 Reset mid-word: start, then 2 bits, then rst for 2 cycles -> all outputs 0; the next start with bits 1,0,1,0 and cy=0 -> res_data=5'b00101.
REQ-035 5+6: sum bits LSB-first 1,1,0,1 with cy_in=0 on the MSB cycle, res_ready=1 -> res_valid=1 in cycle 4 for one cycle, res_data=5'b01011.
REQ-036 9+8: sum bits 1,0,0,0 with cy_in=1 on the MSB cycle -> res_data=5'b10001; cy_in=1 on non-MSB cycles has no effect.
REQ-037 Backpressure: res_ready=0 across two back-to-back words (5'b01011, then 5'b00001) -> res_data stays 5'b01011 and ovf_err=1.
REQ-038 Same-cycle drain: repeat the back-to-back case with res_ready=1 only on the second MSB cycle -> res_valid stays 1, res_data=5'b00001, ovf_err=0.
REQ-039 Resync: start, bits 1,1, then start again with bits 0,0,1,0 and cy=1 -> sync_err=1 and res_data=5'b10100.

Source files
------------

// File: rtl/serial_sum_collector.sv
// Collects LSB-first serial sum bits plus the final carry into a W+1 bit
// result held in a one-entry output register with a valid/ready handshake.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   sum_in        serial sum bit, LSB first
//   cy_in         adder carry, used only on the MSB cycle
//   start         marks bit 0 of a new word
//   res_ready     consumer accepts res_data while res_valid is high
//   res_data      {carry, sum[W-1:0]}
//   res_valid     res_data holds an unconsumed word
//   busy          collector is mid-word
//   ovf_err       sticky: a completed word was dropped
//   sync_err      sticky: start arrived mid-word
module serial_sum_collector #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sum_in,
  input  logic         cy_in,
  input  logic         start,
  input  logic         res_ready,
  output logic [W:0]   res_data,
  output logic         res_valid,
  output logic         busy,
  output logic         ovf_err,
  output logic         sync_err
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [W-1:0]  shift, shift_n;
  logic [W:0]    data_n;
  logic          valid_n;
  logic          ovf_n;
  logic          sync_n;
  logic          done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      shift     <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      ovf_err   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      shift     <= shift_n;
      res_data  <= data_n;
      res_valid <= valid_n;
      ovf_err   <= ovf_n;
      sync_err  <= sync_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    shift_n = shift;
    sync_n  = sync_err;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          shift_n    = '0;
          shift_n[0] = sum_in;
          count_n    = CW'(1);
          state_n    = COLLECT;
        end
      end
      COLLECT: begin
        if (start) begin
          // A start mid-word means we lost alignment: restart on this bit.
          shift_n    = '0;
          shift_n[0] = sum_in;
          count_n    = CW'(1);
          sync_n     = 1'b1;
        end else begin
          shift_n[count] = sum_in;
          if (count == LAST) begin
            done    = 1'b1;
            count_n = '0;
            state_n = IDLE;
          end else begin
            count_n = count + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The output register loads when empty or drained in this same cycle;
  // otherwise a completed word has nowhere to go and is dropped.
  always_comb begin
    data_n  = res_data;
    valid_n = res_valid;
    ovf_n   = ovf_err;
    if (done) begin
      if (!res_valid || res_ready) begin
        data_n  = {cy_in, sum_in, shift[W-2:0]};
        valid_n = 1'b1;
      end else begin
        ovf_n = 1'b1;
      end
    end else if (res_valid && res_ready) begin
      valid_n = 1'b0;
    end
  end

  assign busy = (state == COLLECT);

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed bench for serial_sum_collector (W=4) with a result scoreboard.
// Stimulus pushes expected words; a negedge monitor pops on each handshake.
module tb_serial_sum_collector;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         sum_in;
  logic         cy_in;
  logic         start;
  logic         res_ready;
  logic [W:0]   res_data;
  logic         res_valid;
  logic         busy;
  logic         ovf_err;
  logic         sync_err;

  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q[$];

  serial_sum_collector #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sum_in    (sum_in),
    .cy_in     (cy_in),
    .start     (start),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_valid (res_valid),
    .busy      (busy),
    .ovf_err   (ovf_err),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_cyc(input logic s, input logic b, input logic c);
    start  = s;
    sum_in = b;
    cy_in  = c;
    cyc();
    start  = 1'b0;
  endtask

  // One back-to-back word: b is the sum LSB first, cy lands on the MSB
  // cycle, junk drives cy_in on the other cycles, rdy_msb is res_ready
  // during the MSB cycle only.
  task automatic word(input logic [W-1:0] b, input logic cy,
                      input logic junk, input logic rdy_msb);
    logic keep;
    keep = res_ready;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) res_ready = rdy_msb;
      bit_cyc(i == 0, b[i], (i == W - 1) ? cy : junk);
      if (i == 0) chk("busy_after_start", busy, 1);
      if (i == W - 2) chk("latency_not_early", res_valid, keep ? 0 : 32'(res_valid));
    end
    res_ready = keep;
    cy_in = 1'b0;
    sum_in = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word: got %0h expected none", res_data);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if (res_data !== e) begin
          bad++;
          $display("FAIL res_data: got %0h expected %0h", res_data, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    sum_in = 1'b0;
    cy_in = 1'b0;
    start = 1'b0;
    res_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_data", res_data, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_sync", sync_err, 0);

    // Reset mid-word, then a clean word.
    rst = 1'b0;
    bit_cyc(1'b1, 1'b1, 1'b0);
    bit_cyc(1'b0, 1'b1, 1'b0);
    bit_cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc();
    cyc();
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", res_valid, 0);
    chk("midrst_data", res_data, 0);
    chk("midrst_errs", {ovf_err, sync_err}, 0);
    rst = 1'b0;
    res_ready = 1'b1;
    exp_q.push_back(5'b00101);
    word(4'b0101, 1'b0, 1'b0, 1'b1);
    cyc();

    // 5+6, checking the valid pulse lasts exactly one cycle.
    exp_q.push_back(5'b01011);
    word(4'b1011, 1'b0, 1'b0, 1'b1);
    chk("add_valid_c4", res_valid, 1);
    chk("add_data", res_data, 5'b01011);
    chk("add_busy_idle", busy, 0);
    cyc();
    chk("add_valid_c5", res_valid, 0);

    // 9+8 with carry noise on non-MSB cycles.
    exp_q.push_back(5'b10001);
    word(4'b0001, 1'b1, 1'b1, 1'b1);
    cyc();
    cyc();

    // Backpressure across two back-to-back words.
    pulse_rst();
    res_ready = 1'b0;
    word(4'b1011, 1'b0, 1'b0, 1'b0);
    word(4'b0001, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("bp_valid", res_valid, 1);
    chk("bp_data", res_data, 5'b01011);
    chk("bp_ovf", ovf_err, 1);
    exp_q.push_back(5'b01011);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk("bp_drained", res_valid, 0);
    chk("bp_ovf_sticky", ovf_err, 1);

    // Drain and reload in the same cycle.
    pulse_rst();
    res_ready = 1'b0;
    exp_q.push_back(5'b01011);
    word(4'b1011, 1'b0, 1'b0, 1'b0);
    word(4'b0001, 1'b0, 1'b0, 1'b1);
    chk("sc_valid", res_valid, 1);
    chk("sc_data", res_data, 5'b00001);
    chk("sc_ovf", ovf_err, 0);
    cyc();
    chk("sc_hold", res_data, 5'b00001);
    exp_q.push_back(5'b00001);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk("sc_drained", res_valid, 0);

    // Resync: start arrives after two bits.
    pulse_rst();
    res_ready = 1'b1;
    bit_cyc(1'b1, 1'b1, 1'b0);
    bit_cyc(1'b0, 1'b1, 1'b0);
    exp_q.push_back(5'b10100);
    word(4'b0100, 1'b1, 1'b0, 1'b1);
    chk("rs_sync", sync_err, 1);
    chk("rs_data", res_data, 5'b10100);
    chk("rs_ovf", ovf_err, 0);
    cyc();
    cyc();
    chk("rs_sync_sticky", sync_err, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
